// File: rtl/reg_bank_pkg.sv
// Shared types for the reg_bank register file: opcodes, FSM states, register count.
package reg_bank_pkg;

    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_CLR   = 3'd4,
        OP_SWAP  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } opcode_e;

    typedef enum logic {
        ST_IDLE,
        ST_SWAP2
    } state_e;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational result/flag generation for the single-register ops (WRITE/INC/DEC/CLR).
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  opcode_e          op,
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             writes,
    output logic             carry_en
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        result   = old_val;
        carry    = 1'b0;
        writes   = 1'b0;
        carry_en = 1'b0;
        case (op)
            OP_WRITE: begin
                result = wdata;
                writes = 1'b1;
            end
            OP_INC: begin
                result   = old_val + ONE;
                carry    = (old_val == '1);
                writes   = 1'b1;
                carry_en = 1'b1;
            end
            OP_DEC: begin
                result   = old_val - ONE;
                carry    = (old_val == '0);
                writes   = 1'b1;
                carry_en = 1'b1;
            end
            OP_CLR: begin
                result = '0;
                writes = 1'b1;
            end
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/reg_bank.sv
// Eight-entry register bank with WRITE/INC/DEC/CLR and a two-cycle SWAP.
// Optional REG_BANK_ZERO_R0_EN hardwires r0 to zero and discards writes to it.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [2:0]       addr_a,
    input  logic [2:0]       addr_b,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic             zero,
    output logic             carry
);

`ifdef REG_BANK_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] tmp;
    logic [2:0]       held;
    state_e           state;
    opcode_e          op;

    logic [WIDTH-1:0] val_a, val_b, alu_result;
    logic             alu_zero, alu_carry, alu_writes, alu_carry_en;
    logic             wr_ok_a, wr_ok_held;

    assign op        = opcode_e'(cmd);
    assign cmd_ready = (state == ST_IDLE);

    // r0 reads as zero and rejects writes when hardwired; this also makes
    // flags hold for ops targeting r0, since the write gate covers them too.
    assign val_a      = (ZERO_R0 && addr_a == 3'd0) ? '0 : regs[addr_a];
    assign val_b      = (ZERO_R0 && addr_b == 3'd0) ? '0 : regs[addr_b];
    assign wr_ok_a    = !(ZERO_R0 && addr_a == 3'd0);
    assign wr_ok_held = !(ZERO_R0 && held == 3'd0);

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op),
        .old_val  (val_a),
        .wdata    (wdata),
        .result   (alu_result),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .writes   (alu_writes),
        .carry_en (alu_carry_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            zero  <= 1'b0;
            carry <= 1'b0;
            tmp   <= '0;
            held  <= '0;
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (op == OP_SWAP) begin
                            tmp   <= val_a;
                            held  <= addr_b;
                            state <= ST_SWAP2;
                            if (wr_ok_a) begin
                                regs[addr_a] <= val_b;
                            end
                        end else if (alu_writes && wr_ok_a) begin
                            regs[addr_a] <= alu_result;
                            zero         <= alu_zero;
                            if (alu_carry_en) begin
                                carry <= alu_carry;
                            end
                        end
                    end
                end
                ST_SWAP2: begin
                    if (wr_ok_held) begin
                        regs[held] <= tmp;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign r0 = ZERO_R0 ? '0 : regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank; honours REG_BANK_ZERO_R0_EN when defined.
module tb_reg_bank;

`ifdef REG_BANK_ZERO_R0_EN
    localparam bit Z0 = 1'b1;
`else
    localparam bit Z0 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd = '0, addr_a = '0, addr_b = '0;
    logic [7:0] wdata = '0;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic       zero, carry;
    logic [7:0] obs [8];

    reg_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .wdata     (wdata),
        .r0 (r0), .r1 (r1), .r2 (r2), .r3 (r3),
        .r4 (r4), .r5 (r5), .r6 (r6), .r7 (r7),
        .zero      (zero),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs[0] = r0; obs[1] = r1; obs[2] = r2; obs[3] = r3;
        obs[4] = r4; obs[5] = r5; obs[6] = r6; obs[7] = r7;
    end

    typedef struct packed {
        logic [7:0][7:0] r;
        logic            z;
        logic            c;
        logic            rdy;
    } snap_t;

    snap_t      sb [$];
    int         n_vec = 0;
    int         n_err = 0;

    logic [7:0] m [8];
    logic       mz, mc, m_swap;
    logic [7:0] m_tmp;
    logic [2:0] m_held;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input logic [2:0] i);
        return (Z0 && i == 3'd0) ? 8'h00 : m[i];
    endfunction

    function automatic logic wok(input logic [2:0] i);
        return !(Z0 && i == 3'd0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        mz = 1'b0; mc = 1'b0; m_swap = 1'b0; m_tmp = 8'h00; m_held = 3'd0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] c, input logic [2:0] a,
                              input logic [2:0] b, input logic [7:0] wd);
        logic [7:0] o, res;
        if (m_swap) begin
            if (wok(m_held)) m[m_held] = m_tmp;
            m_swap = 1'b0;
        end else if (v) begin
            o = mrd(a);
            case (c)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    res = (c == 3'd1) ? wd : (c == 3'd2) ? o + 8'd1 :
                          (c == 3'd3) ? o - 8'd1 : 8'h00;
                    if (wok(a)) begin
                        m[a] = res;
                        mz   = (res == 8'h00);
                        if (c == 3'd2) mc = (o == 8'hFF);
                        if (c == 3'd3) mc = (o == 8'h00);
                    end
                end
                3'd5: begin
                    m_tmp  = o;
                    if (wok(a)) m[a] = mrd(b);
                    m_held = b;
                    m_swap = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_expected();
        snap_t s;
        for (int i = 0; i < 8; i++) s.r[i] = mrd(3'(i));
        s.z = mz; s.c = mc; s.rdy = !m_swap;
        sb.push_back(s);
    endtask

    task automatic compare_next(input string tag);
        snap_t s;
        if (sb.size() == 0) begin
            check_eq({tag, ":sb_empty"}, 32'd1, 32'd0);
            return;
        end
        s = sb.pop_front();
        for (int i = 0; i < 8; i++) check_eq($sformatf("%s:r%0d", tag, i), 32'(obs[i]), 32'(s.r[i]));
        check_eq({tag, ":zero"}, 32'(zero), 32'(s.z));
        check_eq({tag, ":carry"}, 32'(carry), 32'(s.c));
        check_eq({tag, ":ready"}, 32'(cmd_ready), 32'(s.rdy));
    endtask

    // Drive at negedge, predict the post-edge state, compare #1 after posedge.
    task automatic step(input string tag, input logic v, input logic [2:0] c,
                        input logic [2:0] a, input logic [2:0] b, input logic [7:0] wd);
        @(negedge clk);
        cmd_valid = v; cmd = c; addr_a = a; addr_b = b; wdata = wd;
        model_step(v, c, a, b, wd);
        push_expected();
        @(posedge clk);
        #1;
        compare_next(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_expected();
        compare_next("reset");
        @(negedge clk);
        rst = 1'b0;

        step("wr_r3", 1'b1, 3'd1, 3'd3, 3'd0, 8'h5A);

        step("wr_r1", 1'b1, 3'd1, 3'd1, 3'd0, 8'hFF);
        step("inc_r1", 1'b1, 3'd2, 3'd1, 3'd0, 8'h00);
        step("dec_r1", 1'b1, 3'd3, 3'd1, 3'd0, 8'h00);

        step("wr_r2", 1'b1, 3'd1, 3'd2, 3'd0, 8'h11);
        step("wr_r5", 1'b1, 3'd1, 3'd5, 3'd0, 8'h22);
        step("swap_acc", 1'b1, 3'd5, 3'd2, 3'd5, 8'h00);
        step("swap_hold", 1'b1, 3'd1, 3'd6, 3'd0, 8'h77);
        step("held_wr", 1'b1, 3'd1, 3'd6, 3'd0, 8'h77);

        step("swap_self", 1'b1, 3'd5, 3'd3, 3'd3, 8'h00);
        step("swap_self2", 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);

        step("rsv6", 1'b1, 3'd6, 3'd4, 3'd1, 8'hEE);
        step("rsv7", 1'b1, 3'd7, 3'd1, 3'd2, 8'hEE);
        step("clr_r6", 1'b1, 3'd4, 3'd6, 3'd0, 8'h00);
        step("no_valid", 1'b0, 3'd1, 3'd4, 3'd0, 8'h99);

        // Reset during SWAP2 must drop the pending write to r5.
        step("rs_wr2", 1'b1, 3'd1, 3'd2, 3'd0, 8'h11);
        step("rs_wr5", 1'b1, 3'd1, 3'd5, 3'd0, 8'h22);
        step("rs_swap", 1'b1, 3'd5, 3'd2, 3'd5, 8'h00);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        push_expected();
        compare_next("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        step("post_rst2", 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);

`ifdef REG_BANK_ZERO_R0_EN
        step("z0_wr3", 1'b1, 3'd1, 3'd3, 3'd0, 8'h05);
        step("z0_inc3", 1'b1, 3'd2, 3'd3, 3'd0, 8'h00);
        step("z0_wr0", 1'b1, 3'd1, 3'd0, 3'd0, 8'h33);
        step("z0_dec0", 1'b1, 3'd3, 3'd0, 3'd0, 8'h00);
        step("z0_wr7", 1'b1, 3'd1, 3'd7, 3'd0, 8'h44);
        step("z0_swap", 1'b1, 3'd5, 3'd0, 3'd7, 8'h00);
        step("z0_swap2", 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
`else
        step("r0_wr", 1'b1, 3'd1, 3'd0, 3'd0, 8'h33);
        step("r0_wr7", 1'b1, 3'd1, 3'd7, 3'd0, 8'h44);
        step("r0_swap", 1'b1, 3'd5, 3'd0, 3'd7, 8'h00);
        step("r0_swap2", 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
`endif

        for (int k = 0; k < 80; k++) begin
            step($sformatf("rnd%0d", k), 1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
